// File: rtl/sn_to_bin_pair.sv
// sn_to_bin_pair: counts ones on two stochastic streams over 2^SNG_WIDTH valid bits, returns the pair via valid/ready.
// Define S2B_SORT_OUT_EN to load the larger result into a_val and the smaller into b_val.
module sn_to_bin_pair #(
   parameter int SNG_WIDTH  = 6,
   parameter int NUM_INPUTS = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 bit_valid,
   input  logic                 bit_a,
   input  logic                 bit_b,
   input  logic                 out_ready,
   output logic                 out_valid,
   output logic [SNG_WIDTH-1:0] a_val,
   output logic [SNG_WIDTH-1:0] b_val,
   output logic                 busy
);
   typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;
   localparam logic [SNG_WIDTH:0] LAST = {1'b0, {SNG_WIDTH{1'b1}}};
   localparam logic [SNG_WIDTH:0] ONE  = {{SNG_WIDTH{1'b0}}, 1'b1};
   state_t               r_state;
   logic [SNG_WIDTH:0]   r_cnt_a, r_cnt_b, r_cyc;
   logic [SNG_WIDTH:0]   w_sum_a, w_sum_b;
   logic [SNG_WIDTH-1:0] w_sat_a, w_sat_b, w_hi, w_lo;

   if (NUM_INPUTS != 2) begin : g_bad_inputs
      $error("sn_to_bin_pair supports exactly two streams");
   end

   assign w_sum_a = r_cnt_a + {{SNG_WIDTH{1'b0}}, bit_a};
   assign w_sum_b = r_cnt_b + {{SNG_WIDTH{1'b0}}, bit_b};
   // a full window of ones overflows into the MSB; clamp instead of wrapping
   assign w_sat_a = w_sum_a[SNG_WIDTH] ? '1 : w_sum_a[SNG_WIDTH-1:0];
   assign w_sat_b = w_sum_b[SNG_WIDTH] ? '1 : w_sum_b[SNG_WIDTH-1:0];
`ifdef S2B_SORT_OUT_EN
   logic [SNG_WIDTH:0] w_diff;
   assign w_diff = {1'b0, w_sat_a} - {1'b0, w_sat_b};
   assign w_hi   = w_diff[SNG_WIDTH] ? w_sat_b : w_sat_a;
   assign w_lo   = w_diff[SNG_WIDTH] ? w_sat_a : w_sat_b;
`else
   assign w_hi = w_sat_a;
   assign w_lo = w_sat_b;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_cnt_a   <= '0;
         r_cnt_b   <= '0;
         r_cyc     <= '0;
         out_valid <= 1'b0;
         a_val     <= '0;
         b_val     <= '0;
         busy      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (start) begin
               r_cnt_a <= '0;
               r_cnt_b <= '0;
               r_cyc   <= '0;
               r_state <= COUNT;
               busy    <= 1'b1;
            end
            COUNT: if (bit_valid) begin
               r_cnt_a <= w_sum_a;
               r_cnt_b <= w_sum_b;
               r_cyc   <= r_cyc + ONE;
               if (r_cyc == LAST) begin
                  r_state   <= HOLD;
                  out_valid <= 1'b1;
                  a_val     <= w_hi;
                  b_val     <= w_lo;
               end
            end
            HOLD: if (out_ready) begin
               out_valid <= 1'b0;
               if (start) begin
                  r_cnt_a <= '0;
                  r_cnt_b <= '0;
                  r_cyc   <= '0;
                  r_state <= COUNT;
               end else begin
                  r_state <= IDLE;
                  busy    <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sn_to_bin_pair.sv
// tb_sn_to_bin_pair: randomized windows checked every cycle against a count-based model, plus literal checks.
module tb_sn_to_bin_pair;
   localparam int W = 6;
   localparam int N = 64;
   localparam int MAXV = 63;
   logic clk = 0, rst = 1, start = 0, bit_valid = 0, bit_a = 0, bit_b = 0, out_ready = 0;
   logic out_valid, busy;
   logic [W-1:0] a_val, b_val;
   int vectors = 0, miscompares = 0;

   sn_to_bin_pair #(.SNG_WIDTH(W), .NUM_INPUTS(2)) dut (
      .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid), .bit_a(bit_a), .bit_b(bit_b),
      .out_ready(out_ready), .out_valid(out_valid), .a_val(a_val), .b_val(b_val), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic int sat(input int c);
      return c > MAXV ? MAXV : c;
   endfunction
   function automatic int hi(input int ca, input int cb);
`ifdef S2B_SORT_OUT_EN
      return sat(ca) > sat(cb) ? sat(ca) : sat(cb);
`else
      return sat(ca);
`endif
   endfunction
   function automatic int lo(input int ca, input int cb);
`ifdef S2B_SORT_OUT_EN
      return sat(ca) > sat(cb) ? sat(cb) : sat(ca);
`else
      return sat(cb);
`endif
   endfunction

   // behavioural model: ones tallies and valid-bit count as plain integers
   bit m_busy = 0, m_counting = 0, m_ov = 0;
   int m_na = 0, m_nb = 0, m_n = 0, m_a = 0, m_b = 0;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy <= 0; m_counting <= 0; m_ov <= 0;
         m_na <= 0; m_nb <= 0; m_n <= 0; m_a <= 0; m_b <= 0;
      end else if (!m_busy) begin
         if (start) begin
            m_busy <= 1; m_counting <= 1; m_na <= 0; m_nb <= 0; m_n <= 0;
         end
      end else if (m_counting) begin
         if (bit_valid) begin
            m_na <= m_na + int'(bit_a);
            m_nb <= m_nb + int'(bit_b);
            m_n  <= m_n + 1;
            if (m_n + 1 == N) begin
               m_counting <= 0;
               m_ov <= 1;
               m_a <= hi(m_na + int'(bit_a), m_nb + int'(bit_b));
               m_b <= lo(m_na + int'(bit_a), m_nb + int'(bit_b));
            end
         end
      end else if (out_ready) begin
         m_ov <= 0;
         if (start) begin
            m_counting <= 1; m_na <= 0; m_nb <= 0; m_n <= 0;
         end else m_busy <= 0;
      end
   end

   always @(negedge clk) begin
      vectors++;
      if (out_valid !== m_ov || busy !== m_busy || int'(a_val) != m_a || int'(b_val) != m_b) begin
         miscompares++;
         $display("FAIL cycle t=%0t got ov=%0b busy=%0b a=%0d b=%0d expected ov=%0b busy=%0b a=%0d b=%0d",
                  $time, out_valid, busy, a_val, b_val, m_ov, m_busy, m_a, m_b);
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic do_start;
      start = 1; bit_valid = 1; bit_a = 1'($urandom_range(1)); bit_b = 1'($urandom_range(1));
      tick;
      start = 0; bit_valid = 0;
   endtask

   task automatic send(input logic [63:0] pa, input logic [63:0] pb, input int gap, input int nb);
      for (int i = 0; i < nb; i++) begin
         while (int'($urandom_range(99)) < gap) begin
            bit_valid = 0; bit_a = 1'($urandom_range(1)); bit_b = 1'($urandom_range(1));
            tick;
         end
         bit_valid = 1; bit_a = pa[i]; bit_b = pb[i];
         tick;
      end
      bit_valid = 0;
   endtask

   task automatic handshake;
      out_ready = 1;
      tick;
      out_ready = 0;
   endtask

   task automatic window(input string nm, input logic [63:0] pa, input logic [63:0] pb, input int gap);
      send(pa, pb, gap, N);
      chk({nm, " ov"}, int'(out_valid), 1);
      chk({nm, " a"}, int'(a_val), hi($countones(pa), $countones(pb)));
      chk({nm, " b"}, int'(b_val), lo($countones(pa), $countones(pb)));
   endtask

   initial begin
      logic [63:0] pa, pb;
      bit b2b;
      repeat (2) tick;
      rst = 0;
      tick;
      chk("reset ov", int'(out_valid), 0);
      chk("reset busy", int'(busy), 0);
      chk("reset a", int'(a_val), 0);
      chk("reset b", int'(b_val), 0);

      do_start;
      chk("t1 busy", int'(busy), 1);
      send('1, '1, 0, N);
      chk("t1 ov", int'(out_valid), 1);
      chk("t1 a sat", int'(a_val), 63);
      chk("t1 b sat", int'(b_val), 63);
      handshake;
      chk("t1 ov after hs", int'(out_valid), 0);
      chk("t1 busy after hs", int'(busy), 0);

      do_start;
      chk("t2 busy", int'(busy), 1);
      send(64'h0000_0000_FFFF_FFFF, 64'h0, 0, N);
`ifdef S2B_SORT_OUT_EN
      chk("t2 a", int'(a_val), 32);
      chk("t2 b", int'(b_val), 0);
`else
      chk("t2 a", int'(a_val), 32);
      chk("t2 b", int'(b_val), 0);
`endif
      chk("t2 busy hold", int'(busy), 1);
      handshake;
      chk("t2 busy after hs", int'(busy), 0);

      pa = 64'h0000_0000_000F_FFFF;
      pb = 64'hFFFF_FFFF_FFF8_0000;
      do_start;
      send(pa, pb, 36, N - 1);
      chk("t3 ov before last", int'(out_valid), 0);
      send(pa >> 63, pb >> 63, 36, 1);
      chk("t3 ov", int'(out_valid), 1);
`ifdef S2B_SORT_OUT_EN
      chk("t3 a", int'(a_val), 45);
      chk("t3 b", int'(b_val), 20);
`else
      chk("t3 a", int'(a_val), 20);
      chk("t3 b", int'(b_val), 45);
`endif
      handshake;

      do_start;
      window("t4 first", 64'h5555_5555_5555_5555, 64'h7, 10);
      for (int k = 0; k < 10; k++) begin
         start = (k == 3);
         tick;
         chk("t4 hold ov", int'(out_valid), 1);
         chk("t4 hold a", int'(a_val), 32);
         chk("t4 hold b", int'(b_val), 3);
      end
      out_ready = 1; start = 1;
      tick;
      out_ready = 0; start = 0;
      chk("t4 b2b ov", int'(out_valid), 0);
      chk("t4 b2b busy", int'(busy), 1);
      window("t4 second", {$urandom, $urandom}, {$urandom, $urandom}, 20);
      handshake;

      do_start;
      send({$urandom, $urandom}, {$urandom, $urandom}, 20, 30);
      #1 rst = 1;
      #1;
      chk("t5 rst ov", int'(out_valid), 0);
      chk("t5 rst busy", int'(busy), 0);
      chk("t5 rst a", int'(a_val), 0);
      chk("t5 rst b", int'(b_val), 0);
      #2 rst = 0;
      tick;
      do_start;
      window("t5 fresh", 64'h00FF_00FF_00FF_00FF, 64'hFFFF_FFFF_FFFF_FFFE, 15);
      handshake;

      do_start;
      send(64'h3FF, 64'hFF_FFFF_FFFF, 10, N);
`ifdef S2B_SORT_OUT_EN
      chk("t6 a", int'(a_val), 40);
      chk("t6 b", int'(b_val), 10);
`else
      chk("t6 a", int'(a_val), 10);
      chk("t6 b", int'(b_val), 40);
`endif
      handshake;
      do_start;
      send(64'h1FF_FFFF, 64'h1FF_FFFF << 30, 10, N);
      chk("t6 tie a", int'(a_val), 25);
      chk("t6 tie b", int'(b_val), 25);
      handshake;

      b2b = 0;
      for (int it = 0; it < 20; it++) begin
         pa = ($urandom_range(7) == 0) ? '1 : {$urandom, $urandom};
         pb = ($urandom_range(7) == 0) ? '1 : {$urandom, $urandom};
         if (!b2b) do_start;
         window("rand", pa, pb, int'($urandom_range(60)));
         repeat ($urandom_range(5)) begin
            start = 1'($urandom_range(1));
            tick;
         end
         b2b = (it != 19) && ($urandom_range(1) == 1);
         out_ready = 1; start = b2b;
         tick;
         out_ready = 0; start = 0;
      end
      tick;
      chk("final busy", int'(busy), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
